// File: rtl/traffic_pkg.sv
// Shared state encoding and default timing constants for the multi-approach
// traffic phase controller and its prescaler.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_ALL_RED = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2,
    S_FLASH   = 2'd3
  } state_e;

  localparam int DEF_CL_PERIOD_TIME = 100;
  localparam int DEF_NUM_DIR        = 2;
  localparam int DEF_GREEN_TIME     = 15;
  localparam int DEF_YELLOW_TIME    = 3;
  localparam int DEF_ALL_RED_TIME   = 2;
  localparam int DEF_PED_EXTRA_TIME = 5;

endpackage

// File: rtl/tl_sec_tick.sv
// One-second prescaler: sec_tick pulses for one cycle every CL_PERIOD_TIME
// enabled cycles; the count restarts from zero whenever en is low.
module tl_sec_tick
  import traffic_pkg::*;
#(
  parameter int CL_PERIOD_TIME = DEF_CL_PERIOD_TIME
) (
  input  logic clk,
  input  logic rstb,
  input  logic en,
  output logic sec_tick
);

  localparam int            PW   = (CL_PERIOD_TIME > 1) ? $clog2(CL_PERIOD_TIME) : 1;
  localparam logic [PW-1:0] LAST = PW'(CL_PERIOD_TIME - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (!en || pre_q == LAST) pre_d = '0;
    else                      pre_d = pre_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) pre_q <= '0;
    else      pre_q <= pre_d;
  end

  assign sec_tick = en && (pre_q == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Multi-approach traffic controller: round-robin green with all-red clearance,
// latched pedestrian extension and night flashing yellow.
// Define TL_PED_SHORTEN_EN to let pending cross-street requests cut a green to YELLOW_TIME.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int CL_PERIOD_TIME = DEF_CL_PERIOD_TIME,
  parameter int NUM_DIR        = DEF_NUM_DIR,
  parameter int GREEN_TIME     = DEF_GREEN_TIME,
  parameter int YELLOW_TIME    = DEF_YELLOW_TIME,
  parameter int ALL_RED_TIME   = DEF_ALL_RED_TIME,
  parameter int PED_EXTRA_TIME = DEF_PED_EXTRA_TIME,
  parameter int DIR_W          = $clog2(NUM_DIR),
  parameter int CNT_W          = $clog2(GREEN_TIME + PED_EXTRA_TIME + 1)
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic               night_mode,
  input  logic [NUM_DIR-1:0] ped_req,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red,
  output logic [DIR_W-1:0]   active_dir,
  output logic [CNT_W-1:0]   cnt_out,
  output logic               phase_done
);

  localparam logic [CNT_W-1:0] T_GREEN     = CNT_W'(GREEN_TIME);
  localparam logic [CNT_W-1:0] T_GREEN_PED = CNT_W'(GREEN_TIME + PED_EXTRA_TIME);
  localparam logic [CNT_W-1:0] T_YELLOW    = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] T_ALL_RED   = CNT_W'(ALL_RED_TIME);
  localparam logic [DIR_W-1:0] LAST_DIR    = DIR_W'(NUM_DIR - 1);

  state_e             state_q, state_d;
  logic [DIR_W-1:0]   dir_q, dir_d, dir_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_DIR-1:0] pend_q, pend_d;
  logic               flash_q, flash_d;
  logic               done_q, done_d;
  logic               sec_tick, expire;
`ifdef TL_PED_SHORTEN_EN
  logic               short_q, short_d;
  logic               other_pend;
`endif

  tl_sec_tick #(.CL_PERIOD_TIME(CL_PERIOD_TIME)) u_sec_tick (
    .clk      (clk),
    .rstb     (rstb),
    .en       (en),
    .sec_tick (sec_tick)
  );

  assign dir_nxt = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_W'(1);
  // FLASH holds cnt at 0 and exits on a tick, so it never counts as an expiry.
  assign expire  = sec_tick && (state_q != S_FLASH) && (cnt_q == CNT_W'(1));
`ifdef TL_PED_SHORTEN_EN
  assign other_pend = |(pend_q & ~(NUM_DIR'(1) << dir_q));
`endif

  // NOTE: every signal this block drives is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    flash_d = flash_q;
    pend_d  = pend_q | ped_req;
    done_d  = expire;
`ifdef TL_PED_SHORTEN_EN
    short_d = short_q;
`endif
    if (sec_tick) begin
      if (state_q == S_FLASH) begin
        if (!night_mode) begin
          state_d = S_ALL_RED;
          cnt_d   = T_ALL_RED;
        end else begin
          flash_d = ~flash_q;
        end
      end else if (expire) begin
        case (state_q)
          S_ALL_RED: begin
            if (night_mode) begin
              state_d = S_FLASH;
              cnt_d   = '0;
              flash_d = 1'b1;
            end else begin
              state_d         = S_GREEN;
              dir_d           = dir_nxt;
              cnt_d           = pend_q[dir_nxt] ? T_GREEN_PED : T_GREEN;
              // Entry clear overrides a same-cycle request: it is served by this green.
              pend_d[dir_nxt] = 1'b0;
`ifdef TL_PED_SHORTEN_EN
              short_d         = 1'b0;
`endif
            end
          end
          S_GREEN: begin
            state_d = S_YELLOW;
            cnt_d   = T_YELLOW;
          end
          S_YELLOW: begin
            state_d = S_ALL_RED;
            cnt_d   = T_ALL_RED;
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
`ifdef TL_PED_SHORTEN_EN
    if (en && state_q == S_GREEN && !short_q && other_pend && cnt_q > T_YELLOW) begin
      cnt_d   = T_YELLOW;
      short_d = 1'b1;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q <= S_ALL_RED;
      dir_q   <= LAST_DIR;
      cnt_q   <= T_ALL_RED;
      pend_q  <= '0;
      flash_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      flash_q <= flash_d;
      done_q  <= done_d;
    end
  end

`ifdef TL_PED_SHORTEN_EN
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) short_q <= 1'b0;
    else      short_q <= short_d;
  end
`endif

  always_comb begin
    green  = '0;
    yellow = '0;
    red    = '1;
    case (state_q)
      S_GREEN: begin
        green[dir_q] = 1'b1;
        red[dir_q]   = 1'b0;
      end
      S_YELLOW: begin
        yellow[dir_q] = 1'b1;
        red[dir_q]    = 1'b0;
      end
      S_FLASH: begin
        red    = '0;
        yellow = {NUM_DIR{flash_q}};
      end
      default: ;
    endcase
  end

  assign active_dir = dir_q;
  assign cnt_out    = cnt_q;
  assign phase_done = done_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed timeline checks plus a
// randomized run compared every cycle against a seconds-level behavioural model.
module tb_traffic_phase_ctrl;

  localparam int CL = 4;
  localparam int N  = 3;
  localparam int GT = 15;
  localparam int YT = 3;
  localparam int AT = 2;
  localparam int PT = 5;
  localparam int DW = 2;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rstb, en, night_mode;
  logic [N-1:0]  ped_req;
  logic [N-1:0]  green, yellow, red;
  logic [DW-1:0] active_dir;
  logic [CW-1:0] cnt_out;
  logic          phase_done;

  traffic_phase_ctrl #(
    .CL_PERIOD_TIME (CL),
    .NUM_DIR        (N),
    .GREEN_TIME     (GT),
    .YELLOW_TIME    (YT),
    .ALL_RED_TIME   (AT),
    .PED_EXTRA_TIME (PT),
    .DIR_W          (DW),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .en         (en),
    .night_mode (night_mode),
    .ped_req    (ped_req),
    .green      (green),
    .yellow     (yellow),
    .red        (red),
    .active_dir (active_dir),
    .cnt_out    (cnt_out),
    .phase_done (phase_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int pd_count = 0;

  // Behavioural model: phase name, seconds left, owning approach, pending buttons.
  typedef enum {M_CLEAR, M_GO, M_WARN, M_BLINK} mphase_e;
  mphase_e m_phase;
  int      m_dir, m_left, m_pre;
  bit      m_pend[N];
  bit      m_blink, m_done, m_short;

  task automatic model_reset();
    m_phase = M_CLEAR;
    m_dir   = N - 1;
    m_left  = AT;
    m_pre   = 0;
    for (int d = 0; d < N; d++) m_pend[d] = 1'b0;
    m_blink = 1'b0;
    m_done  = 1'b0;
    m_short = 1'b0;
  endtask

  task automatic model_edge();
    bit tick, cut;
    bit old_pend[N];
    if (rstb) begin
      model_reset();
      return;
    end
    old_pend = m_pend;
    for (int d = 0; d < N; d++) if (ped_req[d]) m_pend[d] = 1'b1;
    tick = 1'b0;
    if (en) begin
      if (m_pre == CL - 1) begin
        tick  = 1'b1;
        m_pre = 0;
      end else begin
        m_pre++;
      end
    end else begin
      m_pre = 0;
    end
    cut = 1'b0;
`ifdef TL_PED_SHORTEN_EN
    if (en && m_phase == M_GO && !m_short && m_left > YT)
      for (int d = 0; d < N; d++) if (d != m_dir && old_pend[d]) cut = 1'b1;
`endif
    m_done = 1'b0;
    if (tick) begin
      if (m_phase == M_BLINK) begin
        if (!night_mode) begin
          m_phase = M_CLEAR;
          m_left  = AT;
        end else begin
          m_blink = !m_blink;
        end
      end else if (m_left == 1) begin
        m_done = 1'b1;
        if (m_phase == M_CLEAR && night_mode) begin
          m_phase = M_BLINK;
          m_blink = 1'b1;
          m_left  = 0;
        end else if (m_phase == M_CLEAR) begin
          m_dir        = (m_dir + 1) % N;
          m_phase      = M_GO;
          m_left       = GT + (old_pend[m_dir] ? PT : 0);
          m_pend[m_dir] = 1'b0;
          m_short      = 1'b0;
        end else if (m_phase == M_GO) begin
          m_phase = M_WARN;
          m_left  = YT;
        end else begin
          m_phase = M_CLEAR;
          m_left  = AT;
        end
      end else begin
        m_left--;
      end
    end
    if (cut) begin
      m_left  = YT;
      m_short = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] eg, ey, er;
    for (int d = 0; d < N; d++) begin
      eg[d] = (m_phase == M_GO) && (d == m_dir);
      ey[d] = ((m_phase == M_WARN) && (d == m_dir)) || ((m_phase == M_BLINK) && m_blink);
      er[d] = (m_phase != M_BLINK) && !eg[d] && !ey[d];
    end
    check("model_green",  32'(green),      32'(eg));
    check("model_yellow", 32'(yellow),     32'(ey));
    check("model_red",    32'(red),        32'(er));
    check("model_dir",    32'(active_dir), 32'(m_dir));
    check("model_cnt",    32'(cnt_out),    32'(m_left));
    check("model_done",   32'(phase_done), 32'(m_done));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
    pd_count += int'(phase_done);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to_green(input int d, input int budget, input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!(green[d] && phase_done) && k < budget);
    check({tag, "_reached"}, 32'(green[d] && phase_done), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_red"},    32'(red),        32'b111);
    check({tag, "_green"},  32'(green),      32'd0);
    check({tag, "_yellow"}, 32'(yellow),     32'd0);
    check({tag, "_dir"},    32'(active_dir), 32'd2);
    check({tag, "_cnt"},    32'(cnt_out),    32'd2);
    check({tag, "_done"},   32'(phase_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rstb = 1'b1; en = 1'b1; night_mode = 1'b0; ped_req = '0;
    model_reset();
    run(3);
    check_reset_vals("reset");
    rstb = 1'b0;

    // Timeline: all-red 2 ticks, green[0] 15, yellow 3, all-red 2, green[1].
    run(7);
    check("pre_green_cnt", 32'(cnt_out), 32'd1);
    run(1);
    check("g0_green", 32'(green),      32'b001);
    check("g0_cnt",   32'(cnt_out),    32'd15);
    check("g0_done",  32'(phase_done), 32'd1);
    check("g0_dir",   32'(active_dir), 32'd0);
    pd_count = 0;
    run(60);
    check("y0_yellow", 32'(yellow),  32'b001);
    check("y0_cnt",    32'(cnt_out), 32'd3);
    run(12);
    check("ar_red", 32'(red),     32'b111);
    check("ar_cnt", 32'(cnt_out), 32'd2);
    run(8);
    check("g1_green", 32'(green),      32'b010);
    check("g1_cnt",   32'(cnt_out),    32'd15);
    check("g1_dir",   32'(active_dir), 32'd1);
    run(160);
    check("rot_dir",   32'(active_dir), 32'd0);
    check("rot_green", 32'(green),      32'b001);
    check("rot_pulses", 32'(pd_count),  32'd9);

    // Pedestrian extension on approach 1, then cleared.
    ped_req = 3'b010;
    step();
    ped_req = '0;
    run_to_green(1, 200, "ped_g1");
    check("ped_ext_cnt", 32'(cnt_out), 32'd20);
    run_to_green(1, 400, "ped_g1_again");
    check("ped_cleared_cnt", 32'(cnt_out), 32'd15);

    // Night mode asserted mid-green: green/yellow/all-red complete, then flashing.
    run(10);
    night_mode = 1'b1;
    k = 0;
    do begin step(); k++; end while (red != '0 && k < 300);
    check("flash_reached", 32'(red == '0), 32'd1);
    check("flash_y1",  32'(yellow),     32'b111);
    check("flash_g",   32'(green),      32'd0);
    check("flash_cnt", 32'(cnt_out),    32'd0);
    check("flash_dir", 32'(active_dir), 32'd1);
    run(4);
    check("flash_y0", 32'(yellow), 32'd0);
    run(4);
    check("flash_y1b", 32'(yellow), 32'b111);
    night_mode = 1'b0;
    run(4);
    check("unflash_red", 32'(red),     32'b111);
    check("unflash_cnt", 32'(cnt_out), 32'd2);
    run_to_green(2, 100, "after_night");
    check("after_night_cnt", 32'(cnt_out), 32'd15);

    // Enable hold mid-green at cnt_out=7.
    k = 0;
    do begin step(); k++; end while (cnt_out != 5'd7 && k < 100);
    check("hold_reached", 32'(cnt_out), 32'd7);
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) ped_req = 3'b001;
      if (i == 21) ped_req = '0;
      step();
      check("hold_cnt",   32'(cnt_out), 32'd7);
      check("hold_green", 32'(green),   32'b100);
    end
    en = 1'b1;
    run(3);
    check("resume_cnt7", 32'(cnt_out), 32'd7);
    run(1);
    check("resume_cnt6", 32'(cnt_out), 32'd6);

    // Asynchronous reset in the middle of yellow.
    k = 0;
    do begin step(); k++; end while (yellow != 3'b100 && k < 100);
    check("yellow_reached", 32'(yellow), 32'b100);
    run(2);
    #2;
    rstb = 1'b1;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    run(2);
    rstb = 1'b0;

`ifdef TL_PED_SHORTEN_EN
    run_to_green(0, 100, "short_g0");
    k = 0;
    do begin step(); k++; end while (cnt_out != 5'd12 && k < 100);
    ped_req = 3'b010;
    step();
    ped_req = '0;
    step();
    check("short_cnt", 32'(cnt_out), 32'd3);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ped_req = ($urandom_range(0, 19) == 0) ? N'($urandom) : '0;
      en      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 299) == 0) night_mode = ~night_mode;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised multi-approach intersection controller, the successor to the single-approach red/yellow/green sequencer. It drives one green/yellow/red triple per approach (NUM_DIR approaches) and rotates green round-robin with an all-red clearance phase between approaches. It also adds latched pedestrian-extension requests and a night flashing-yellow mode. Its outputs feed the lamp drivers and the existing two-digit countdown display path through cnt_out.

Parameters:
CL_PERIOD_TIME, 100, clk cycles per one-second tick
NUM_DIR, 2, number of approaches; minimum 2
GREEN_TIME, 15, green duration in seconds
YELLOW_TIME, 3, yellow duration in seconds
ALL_RED_TIME, 2, all-red clearance duration in seconds
PED_EXTRA_TIME, 5, seconds added to green when that approach has a pending pedestrian request
DIR_W, $clog2(NUM_DIR), width of active_dir
CNT_W, $clog2(GREEN_TIME+PED_EXTRA_TIME+1), countdown width

Ports:
clk  in  1  system clock
rstb  in  1  reset; asynchronous, active-high (1 = reset)
en  in  1  run enable; 0 freezes all state
night_mode  in  1  request flashing-yellow operation
ped_req  in  NUM_DIR  per-approach pedestrian button, level or pulse
green  out  NUM_DIR  green lamp per approach
yellow  out  NUM_DIR  yellow lamp per approach
red  out  NUM_DIR  red lamp per approach
active_dir  out  DIR_W  approach currently owning green/yellow
cnt_out  out  CNT_W  seconds remaining in current phase
phase_done  out  1  one-cycle pulse on each countdown expiry

Behaviour:
- Tick: sec_tick pulses 1 cycle every CL_PERIOD_TIME enabled cycles. The prescaler resets to 0 and holds while en=0.
- States: S_ALL_RED, S_GREEN, S_YELLOW, S_FLASH.
- Reset values: state S_ALL_RED, active_dir=NUM_DIR-1, cnt_out=ALL_RED_TIME, red=all 1, green=0, yellow=0, phase_done=0, ped_pending=0.
- Countdown: the phase length is loaded on entry and decremented on sec_tick. On sec_tick with cnt_out==1 the phase expires: phase_done pulses, the next state is entered, and the next length is loaded in the same cycle. Each phase therefore lasts exactly its length in ticks, and cnt_out shows N..1.
- S_ALL_RED expiry, night_mode=0: active_dir <= (active_dir+1) mod NUM_DIR, go to S_GREEN. Load GREEN_TIME, or GREEN_TIME+PED_EXTRA_TIME if ped_pending[new dir]. Clear that pending bit.
- S_ALL_RED expiry, night_mode=1: go to S_FLASH.
- S_GREEN expiry: go to S_YELLOW, load YELLOW_TIME.
- S_YELLOW expiry: go to S_ALL_RED, load ALL_RED_TIME.
- Night mode is sampled only at S_ALL_RED expiry, so an in-progress green/yellow always completes.
- Lamps: active_dir shows green in S_GREEN and yellow in S_YELLOW; all other approaches show red. S_ALL_RED shows red on all approaches. Exactly one lamp per approach is lit outside S_FLASH.
- S_FLASH: red=0, green=0. yellow is all 1 / all 0, toggling every sec_tick and starting at 1. cnt_out=0. On the first sec_tick with night_mode=0, go to S_ALL_RED with ALL_RED_TIME loaded; active_dir is unchanged.
- Pedestrian: ped_req[d]=1 sets ped_pending[d] in any state. If the set and the clear on green entry for the same d fall in the same cycle, the clear wins (request counted as served).
- en=0: FSM, counter, pending bits and outputs hold. ped_req is still latched.
- Reset mid-phase: immediate return to reset values, all-red.

Optional Feature:
TL_PED_SHORTEN_EN.
- Defined: in S_GREEN, when any other approach has ped_pending set and cnt_out > YELLOW_TIME, cnt_out is loaded with YELLOW_TIME once per green phase.
- Not defined: green always runs its full loaded length.

Decomposition:
- Shared package/header traffic_pkg: state encodings (S_ALL_RED=0, S_GREEN=1, S_YELLOW=2, S_FLASH=3) and default timing constants.
- Sub-module tl_sec_tick (prescaler with en hold), instantiated once.
- The FSM, counter and pedestrian latches stay in the top-level module.

Test Plan:
- Reset, CL_PERIOD_TIME=4, NUM_DIR=2 -> all red, cnt_out=2. After 2 ticks, green[0]=1 and cnt_out=15. After 15 ticks, yellow[0] for 3. Then all-red 2, then green[1].
- NUM_DIR=3, run 3 full cycles -> active_dir sequence 0,1,2,0. phase_done pulses 9 times at expiries only.
- ped_req[1] pulse during green[0] -> green[1] loads 20. Next green[1] loads 15 (pending cleared).
- night_mode=1 during green[0] -> yellow 3 and all-red 2 complete, then flashing yellow with period 2 ticks. Deassert -> all-red 2, then green[1].
- en=0 for 50 cycles mid-green at cnt_out=7 -> all outputs constant, cnt_out stays 7. Resumes after a full CL_PERIOD_TIME.
- rstb=1 mid-yellow -> outputs return to reset values asynchronously, with no wait for clk. With TL_PED_SHORTEN_EN defined: ped_req[1] at green[0] cnt_out=12 -> cnt_out becomes 3.
